// File: rtl/udsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udsp_pkg
// Purpose  : Shared uDSP types and defaults: data-memory geometry, region
//            bases and the sample-exchange state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package udsp_pkg;

   localparam int c_DAW_DEFAULT = 10;
   localparam int c_DWW_DEFAULT = 36;

   localparam logic [9:0] c_IN_BASE_DEFAULT  = 10'h000;
   localparam logic [9:0] c_OUT_BASE_DEFAULT = 10'h080;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_SEND    = 3'd3,
      ST_FILL    = 3'd4,
      ST_KICK    = 3'd5
   } xchg_state_t;

endpackage : udsp_pkg
`default_nettype wire

// File: rtl/sample_exchanger.sv
`default_nettype none
// ============================================================================
// Module   : sample_exchanger
// Purpose  : Per-tick drain of DSP output samples to a stream, refill of the
//            input region from a stream, then a one-cycle uDSP start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sample_exchanger
   import udsp_pkg::*;
#(
   parameter int             DAW      = c_DAW_DEFAULT,
   parameter int             DWW      = c_DWW_DEFAULT,
   parameter int             NCH      = 8,
   parameter logic [DAW-1:0] IN_BASE  = DAW'(c_IN_BASE_DEFAULT),
   parameter logic [DAW-1:0] OUT_BASE = DAW'(c_OUT_BASE_DEFAULT)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sampleTick,
   output logic [DAW-1:0] addrM,
   input  logic [DWW-1:0] dataMrd,
   output logic [DWW-1:0] dataMwr,
   output logic           writeEnM,
   input  logic           inValid,
   output logic           inReady,
   input  logic [DWW-1:0] inData,
   output logic           outValid,
   input  logic           outReady,
   output logic [DWW-1:0] outData,
   output logic           start,
   output logic           busy,
   output logic           overrun
);

   localparam logic [DAW-1:0] c_LAST_IDX = DAW'(NCH - 1);
   localparam logic [DAW-1:0] c_ONE      = DAW'(1);

   xchg_state_t    r_state;
   logic [DAW-1:0] r_idx;
   logic [DAW-1:0] r_rd_addr;
   logic [DWW-1:0] r_out_data;
   logic           r_out_valid;
   logic           r_in_ready;
   logic           r_start;
   logic           r_busy;
   logic           r_overrun;

   logic           w_fill_hs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_rd_addr   <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         // Busy includes the KICK cycle, so a tick coinciding with KICK->IDLE is dropped.
         if (sampleTick && r_busy) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (sampleTick) begin
                  r_state   <= ST_RD_ADDR;
                  r_idx     <= '0;
                  r_rd_addr <= OUT_BASE;
                  r_busy    <= 1'b1;
               end
            end
            ST_RD_ADDR: begin
               r_state   <= ST_RD_WAIT;
               r_rd_addr <= '0;
            end
            ST_RD_WAIT: begin
               r_out_data  <= dataMrd;
               r_out_valid <= 1'b1;
               r_state     <= ST_SEND;
            end
            ST_SEND: begin
               if (outReady) begin
                  r_out_valid <= 1'b0;
                  if (r_idx == c_LAST_IDX) begin
                     r_idx      <= '0;
                     r_in_ready <= 1'b1;
                     r_state    <= ST_FILL;
                  end else begin
                     r_idx     <= r_idx + c_ONE;
                     r_rd_addr <= OUT_BASE + r_idx + c_ONE;
                     r_state   <= ST_RD_ADDR;
                  end
               end
            end
            ST_FILL: begin
               if (inValid) begin
                  if (r_idx == c_LAST_IDX) begin
                     r_idx      <= '0;
                     r_in_ready <= 1'b0;
                     r_start    <= 1'b1;
                     r_state    <= ST_KICK;
                  end else begin
                     r_idx <= r_idx + c_ONE;
                  end
               end
            end
            ST_KICK: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_idx       <= '0;
               r_rd_addr   <= '0;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // The write must land in the handshake cycle itself, so the port is steered combinationally.
   assign w_fill_hs = r_in_ready & inValid;
   assign addrM     = w_fill_hs ? (IN_BASE + r_idx) : r_rd_addr;
   assign dataMwr   = w_fill_hs ? inData : '0;
   assign writeEnM  = w_fill_hs;

   assign inReady   = r_in_ready;
   assign outValid  = r_out_valid;
   assign outData   = r_out_data;
   assign start     = r_start;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule : sample_exchanger
`default_nettype wire

// File: tb/tb_sample_exchanger.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_exchanger
// Purpose  : Directed self-checking bench for sample_exchanger (NCH=8 and
//            an NCH=1 instance whose output region sits at the top address).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_exchanger;

   localparam logic [35:0] c_IN_BASE_VAL = 36'h1_0000_0000;

   logic        clk;
   logic        reset;
   // main instance
   logic        sampleTick;
   logic [9:0]  addrM;
   logic [35:0] dataMrd;
   logic [35:0] dataMwr;
   logic        writeEnM;
   logic        inValid;
   logic        inReady;
   logic [35:0] inData;
   logic        outValid;
   logic        outReady;
   logic [35:0] outData;
   logic        start;
   logic        busy;
   logic        overrun;
   // single-channel instance
   logic        tick1;
   logic [9:0]  addr1;
   logic [35:0] rd1;
   logic [35:0] wr1;
   logic        we1;
   logic        inr1;
   logic        outv1;
   logic [35:0] outd1;
   logic        start1;
   logic        busy1;
   logic        ovr1;

   logic [35:0] mem  [0:1023];
   logic [35:0] mem1 [0:1023];

   int          checks;
   int          failures;
   int          cyc;
   int          in_idx;
   int          start_cnt, last_start_cyc;
   int          first_busy_cyc, last_busy_cyc;
   logic [9:0]  first_addr;
   int          wr_cnt, last_wr_cyc, we_bad;
   int          rd84_cyc, hs103_cyc;
   int          ov_drop, ov_change;
   logic [35:0] out_q [$];
   logic        prev_busy, prev_ov, prev_hs;
   logic [35:0] prev_data;
   int          start1_cnt, last_start1_cyc, rd3ff_cnt, wr1_cnt;
   logic [35:0] out1;

   assign inData = c_IN_BASE_VAL + 36'(in_idx);

   sample_exchanger u_dut (
      .clk(clk), .reset(reset), .sampleTick(sampleTick),
      .addrM(addrM), .dataMrd(dataMrd), .dataMwr(dataMwr), .writeEnM(writeEnM),
      .inValid(inValid), .inReady(inReady), .inData(inData),
      .outValid(outValid), .outReady(outReady), .outData(outData),
      .start(start), .busy(busy), .overrun(overrun)
   );

   sample_exchanger #(.NCH(1), .OUT_BASE(10'h3FF)) u_dut1 (
      .clk(clk), .reset(reset), .sampleTick(tick1),
      .addrM(addr1), .dataMrd(rd1), .dataMwr(wr1), .writeEnM(we1),
      .inValid(1'b1), .inReady(inr1), .inData(36'hABC),
      .outValid(outv1), .outReady(1'b1), .outData(outd1),
      .start(start1), .busy(busy1), .overrun(ovr1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memories: registered read, one cycle after the address.
   always @(posedge clk) begin
      if (writeEnM) mem[addrM] <= dataMwr;
      dataMrd <= mem[addrM];
      if (we1) mem1[addr1] <= wr1;
      rd1 <= mem1[addr1];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && inValid && inReady) in_idx <= in_idx + 1;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (start) begin start_cnt++; last_start_cyc = cyc; end
         if (busy && !prev_busy) begin first_busy_cyc = cyc; first_addr = addrM; end
         if (busy) last_busy_cyc = cyc;
         if (writeEnM) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (!inValid || !inReady) we_bad++;
         end
         if (outValid && outReady) begin
            out_q.push_back(outData);
            if (outData == 36'd103) hs103_cyc = cyc;
         end
         if (busy && !writeEnM && addrM == 10'h084 && rd84_cyc < 0) rd84_cyc = cyc;
         if (prev_ov && !prev_hs && !outValid) ov_drop++;
         if (prev_ov && !prev_hs && outValid && outData !== prev_data) ov_change++;
         if (start1) begin start1_cnt++; last_start1_cyc = cyc; end
         if (busy1 && !we1 && addr1 == 10'h3FF) rd3ff_cnt++;
         if (we1) wr1_cnt++;
         if (outv1) out1 = outd1;
      end
      prev_busy = busy;
      prev_ov   = outValid;
      prev_hs   = outValid && outReady;
      prev_data = outData;
   end

   task automatic clear_stats();
      start_cnt = 0; last_start_cyc = -1;
      first_busy_cyc = -1; last_busy_cyc = -1; first_addr = '0;
      wr_cnt = 0; last_wr_cyc = -1; we_bad = 0;
      rd84_cyc = -1; hs103_cyc = -1;
      ov_drop = 0; ov_change = 0;
      out_q.delete();
      in_idx = 0;
   endtask

   task automatic do_tick(output int t);
      @(posedge clk); #1;
      sampleTick = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      sampleTick = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (start_cnt > 0 && !busy) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (addrM !== 10'd0) begin failures++; $display("FAIL reset_addrM got=%h want=0", addrM); end
      checks++; if (dataMwr !== 36'd0) begin failures++; $display("FAIL reset_dataMwr got=%h want=0", dataMwr); end
      checks++; if (writeEnM !== 1'b0) begin failures++; $display("FAIL reset_writeEnM got=%b want=0", writeEnM); end
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b want=0", outValid); end
      checks++; if (outData !== 36'd0) begin failures++; $display("FAIL reset_outData got=%h want=0", outData); end
      checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL reset_inReady got=%b want=0", inReady); end
      checks++; if ({start, busy, overrun} !== 3'b000) begin failures++; $display("FAIL reset_start_busy_overrun got=%b want=000", {start, busy, overrun}); end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      int t;
      bit ok;
      for (int k = 0; k < 8; k++) begin
         mem[10'h080 + k] = 36'(100 + k);
         mem[k] = '0;
      end
      clear_stats();
      outReady = 1'b1; inValid = 1'b1;
      do_tick(t);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no_start want=start"); end
      checks++; if (out_q.size() != 8) begin failures++; $display("FAIL basic_out_count got=%0d want=8", out_q.size()); end
      for (int k = 0; k < 8 && k < out_q.size(); k++) begin
         checks++;
         if (out_q[k] !== 36'(100 + k)) begin failures++; $display("FAIL basic_out[%0d] got=%0d want=%0d", k, out_q[k], 100 + k); end
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (mem[k] !== c_IN_BASE_VAL + 36'(k)) begin failures++; $display("FAIL basic_mem[%0d] got=%h want=%h", k, mem[k], c_IN_BASE_VAL + 36'(k)); end
      end
      checks++; if (start_cnt != 1) begin failures++; $display("FAIL basic_start_count got=%0d want=1", start_cnt); end
      checks++; if (last_start_cyc != t + 33) begin failures++; $display("FAIL basic_start_time got=%0d want=%0d", last_start_cyc - t, 33); end
      checks++; if (first_busy_cyc != t + 1) begin failures++; $display("FAIL basic_busy_first got=%0d want=1", first_busy_cyc - t); end
      checks++; if (last_busy_cyc != t + 33) begin failures++; $display("FAIL basic_busy_last got=%0d want=33", last_busy_cyc - t); end
      checks++; if (first_addr !== 10'h080) begin failures++; $display("FAIL basic_first_read got=%h want=080", first_addr); end
      checks++; if (we_bad != 0 || wr_cnt != 8) begin failures++; $display("FAIL basic_writes got=%0d/%0d want=8/0", wr_cnt, we_bad); end
   endtask

   task automatic test_backpressure();
      int t;
      int hold;
      bit ok;
      clear_stats();
      outReady = 1'b1; inValid = 1'b1;
      do_tick(t);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (outValid && outData == 36'd102) break;
      end
      @(posedge clk); #1;
      outReady = 1'b0;
      hold = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (outValid && outData == 36'd103) hold++;
         if (hold == 10) break;
      end
      @(posedge clk); #1;
      outReady = 1'b1;
      wait_done(ok);
      checks++; if (hold != 10 || !ok) begin failures++; $display("FAIL bp_hold got=%0d/%0b want=10/1", hold, ok); end
      checks++; if (ov_change != 0 || ov_drop != 0) begin failures++; $display("FAIL bp_stable got=change%0d_drop%0d want=0_0", ov_change, ov_drop); end
      checks++; if (hs103_cyc < 0 || rd84_cyc <= hs103_cyc) begin failures++; $display("FAIL bp_read_order got=rd84@%0d hs103@%0d want=rd_after_hs", rd84_cyc, hs103_cyc); end
      checks++; if (out_q.size() != 8 || out_q[3] !== 36'd103) begin failures++; $display("FAIL bp_out3 got=%0d want=103", (out_q.size() > 3) ? out_q[3] : 36'd0); end
      checks++; if (last_start_cyc != t + 43 || start_cnt != 1) begin failures++; $display("FAIL bp_start got=%0d want=43", last_start_cyc - t); end
   endtask

   task automatic test_in_toggle();
      int t;
      bit ok;
      for (int k = 0; k < 8; k++) mem[k] = '0;
      clear_stats();
      outReady = 1'b1; inValid = 1'b0;
      do_tick(t);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         inValid = ~inValid;
         if (start_cnt > 0 && !busy) begin ok = 1'b1; break; end
      end
      inValid = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (!ok) begin failures++; $display("FAIL tog_timeout got=no_start want=start"); end
      checks++; if (wr_cnt != 8) begin failures++; $display("FAIL tog_writes got=%0d want=8", wr_cnt); end
      checks++; if (we_bad != 0) begin failures++; $display("FAIL tog_we_no_hs got=%0d want=0", we_bad); end
      checks++; if (start_cnt != 1 || last_start_cyc != last_wr_cyc + 1) begin failures++; $display("FAIL tog_start_after_write got=%0d want=%0d", last_start_cyc, last_wr_cyc + 1); end
      checks++; if (mem[7] !== c_IN_BASE_VAL + 36'd7 || mem[0] !== c_IN_BASE_VAL) begin failures++; $display("FAIL tog_mem got=%h/%h want=%h/%h", mem[0], mem[7], c_IN_BASE_VAL, c_IN_BASE_VAL + 36'd7); end
   endtask

   task automatic test_overrun();
      int t;
      bit ok;
      clear_stats();
      outReady = 1'b1; inValid = 1'b1;
      do_tick(t);
      while (cyc < t + 10) begin @(posedge clk); #1; end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b want=0", overrun); end
      sampleTick = 1'b1;
      @(posedge clk); #1;
      sampleTick = 1'b0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", overrun); end
      wait_done(ok);
      repeat (20) @(negedge clk);
      checks++; if (!ok || start_cnt != 1) begin failures++; $display("FAIL ovr_single_start got=%0d want=1", start_cnt); end
      checks++; if (out_q.size() != 8 || last_start_cyc != t + 33) begin failures++; $display("FAIL ovr_frame got=%0d_samples_start%0d want=8_33", out_q.size(), last_start_cyc - t); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
   endtask

   task automatic test_midreset();
      int t;
      bit ok;
      clear_stats();
      outReady = 1'b1; inValid = 1'b1;
      do_tick(t);
      while (cyc < t + 15) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || outValid !== 1'b0) begin failures++; $display("FAIL mrst_busy_valid got=%b%b want=00", busy, outValid); end
      checks++; if (outData !== 36'd0 || addrM !== 10'd0) begin failures++; $display("FAIL mrst_data_addr got=%h/%h want=0/0", outData, addrM); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mrst_overrun got=%b want=0", overrun); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (50) @(negedge clk);
      checks++; if (start_cnt != 0) begin failures++; $display("FAIL mrst_no_start got=%0d want=0", start_cnt); end
      clear_stats();
      do_tick(t);
      wait_done(ok);
      checks++; if (first_addr !== 10'h080) begin failures++; $display("FAIL mrst_restart_addr got=%h want=080", first_addr); end
      checks++; if (!ok || out_q.size() != 8 || out_q[0] !== 36'd100 || last_start_cyc != t + 33) begin failures++; $display("FAIL mrst_restart_frame got=%0d_samples_start%0d want=8_33", out_q.size(), last_start_cyc - t); end
   endtask

   task automatic test_nch1();
      int t;
      mem1[10'h3FF] = 36'h123;
      mem1[0] = '0;
      start1_cnt = 0; last_start1_cyc = -1; rd3ff_cnt = 0; wr1_cnt = 0; out1 = '0;
      @(posedge clk); #1;
      tick1 = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      tick1 = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (start1_cnt != 1 || last_start1_cyc != t + 5) begin failures++; $display("FAIL n1_start got=%0d@%0d want=1@5", start1_cnt, last_start1_cyc - t); end
      checks++; if (rd3ff_cnt != 1) begin failures++; $display("FAIL n1_reads got=%0d want=1", rd3ff_cnt); end
      checks++; if (wr1_cnt != 1 || mem1[0] !== 36'hABC) begin failures++; $display("FAIL n1_write got=%0d/%h want=1/abc", wr1_cnt, mem1[0]); end
      checks++; if (out1 !== 36'h123 || ovr1 !== 1'b0) begin failures++; $display("FAIL n1_out got=%h/%b want=123/0", out1, ovr1); end
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      sampleTick = 1'b0; tick1 = 1'b0;
      inValid = 1'b0; outReady = 1'b0;
      prev_busy = 1'b0; prev_ov = 1'b0; prev_hs = 1'b0; prev_data = '0;
      start1_cnt = 0; last_start1_cyc = -1; rd3ff_cnt = 0; wr1_cnt = 0; out1 = '0;
      for (int a = 0; a < 1024; a++) begin mem[a] = '0; mem1[a] = '0; end
      clear_stats();
      test_reset();
      test_basic();
      test_backpressure();
      test_in_toggle();
      test_overrun();
      test_midreset();
      test_nch1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sample_exchanger
`default_nettype wire

// File: doc/sample_exchanger.md
# sample_exchanger

Frame-rate I/O engine on the host side of the DSP data memory. On each sample tick it drains the DSP's output samples from data memory onto an outgoing stream. It then fills the input region with samples from an incoming stream and pulses `start` to restart the uDSP program. It is the counterpart of the uDSP data ports: it writes what the core reads and reads what the core writes, through the memory's second port.

## Interface
Parameters:
- DAW, 10, data memory address width (3-bit segment + 7-bit word)
- DWW, 36, data word width (Q5.30 samples)
- NCH, 8, samples exchanged per direction per frame (1..128)
- IN_BASE, 10'h000, first address of input region
- OUT_BASE, 10'h080, first address of output region

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- sampleTick  in  1  one-cycle frame strobe
- addrM  out  DAW  data memory address (second port)
- dataMrd  in  DWW  memory read data, valid one cycle after addrM
- dataMwr  out  DWW  memory write data
- writeEnM  out  1  memory write enable
- inValid / inReady  in / out  1  input stream handshake
- inData  in  DWW  input sample
- outValid / outReady  out / in  1  output stream handshake
- outData  out  DWW  output sample
- start  out  1  one-cycle pulse to uDSP `start`
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: a tick arrived while busy

## Operation
- States: IDLE → RD_ADDR → RD_WAIT → SEND → (repeat NCH times) → FILL → KICK → IDLE.
- IDLE: on `sampleTick`, clear the index, go to RD_ADDR.
- RD_ADDR: addrM = OUT_BASE + idx, writeEnM = 0. Next state is RD_WAIT.
- RD_WAIT: register dataMrd into outData. Next state is SEND.
- SEND: outValid = 1 and outData held stable until outReady. On handshake, idx++. If idx was NCH-1, clear idx and go to FILL; otherwise go to RD_ADDR.
- FILL: inReady = 1. On inValid & inReady, in the same cycle: addrM = IN_BASE + idx, dataMwr = inData, writeEnM = 1, idx++. After the NCH-th write, go to KICK.
- KICK: start = 1 for exactly one cycle, then IDLE.
- Addresses wrap modulo 2^DAW. IN_BASE and OUT_BASE regions must not overlap; this is an integration rule and is not checked.
- `sampleTick` while busy: the tick is dropped, overrun is set (sticky until reset), and the exchange in progress is unaffected.
- `sampleTick` in the same cycle as the KICK→IDLE transition counts as busy: the tick is dropped and overrun is set.
- Integration constraint: uDSP program length plus exchange time must be less than the tick period.

## Timing
- Reset (async): state = IDLE, idx = 0. All outputs are 0: addrM, dataMwr, writeEnM, outValid, outData, inReady, start, busy, overrun.
- Tick at cycle T → RD_ADDR at T+1, outValid at T+3 for the first sample.
- Minimum cost per output sample is 3 cycles. Minimum cost per input sample is 1 cycle.
- With both streams always ready: start is high at T + 3·NCH + NCH + 1 = T + 33 (NCH = 8).
- outValid never drops without a handshake. inReady is high only in FILL.
- Reset mid-frame: the exchange is abandoned immediately, no start pulse is issued, and partial writes remain in memory.

## Structure
- Shared package `udsp_pkg`: state enum, DAW/DWW defaults, region base constants. The uDSP opcode constants belong in the same package.
- Single module, no sub-module. The existing `posedgeFF` may hold outData, idx and overrun.

## Test plan
- Memory preloaded with OUT_BASE+k = k+100, k = 0..7; tick with outReady = 1 and in stream supplying 36'h1_0000_0000+k → out stream yields 100..107 in order, memory at 0..7 holds 1_0000_0000..1_0000_0007, a single start pulse occurs at T+33, and busy is high from T+1 to T+33.
- outReady held low for 10 cycles on sample 3 → outData stays at 103 with outValid high throughout, and there is no read of OUT_BASE+4 until the handshake.
- inValid toggled 1,0,1,0… in FILL → exactly 8 writes occur, writeEnM is high only on handshake cycles, and start follows the 8th write.
- Second tick at T+10 → overrun = 1, the current frame completes normally, and only one start pulse occurs; overrun stays set until reset.
- Reset asserted at T+15 (mid-drain) → all outputs are 0 asynchronously, no start pulse follows, and the next tick begins cleanly at OUT_BASE+0.
- NCH = 1, OUT_BASE = 10'h3FF → a single read at 3FF, a single write at IN_BASE, and start at T+5.
